// File: rtl/counter_drv_pkg.sv
// Shared types and defaults for the counter stimulus driver.
// Optional abort support is enabled by defining COUNTER_DRV_ABORT_EN.
package counter_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_e;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/counter_drv_gap_timer.sv
// Loadable down-counter timing the idle cycles between count pulses.
// zero_o is high once the loaded value has been counted out.
module counter_drv_gap_timer #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [GAP_W-1:0] val_i,
  output logic             zero_o
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/counter_stim_driver.sv
// Turns queued burst commands into registered mode/count stimulus.
// Define COUNTER_DRV_ABORT_EN to add the abort input and aborted output.
module counter_stim_driver
  import counter_drv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
`ifdef COUNTER_DRV_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             mode,
  output logic             count,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued
);

  state_e state_q;
  state_e state_d;

  logic             mode_l_q;
  logic [CNT_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic             mode_q;
  logic             count_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] issued_q;

  logic accept;
  logic last;
  logic tmr_load;
  logic tmr_en;
  logic tmr_zero;
  logic abort_take;

  assign accept = cmd_valid && (state_q == IDLE);
  assign last   = ({1'b0, issued_q} + 1'b1) == {1'b0, len_q};

`ifdef COUNTER_DRV_ABORT_EN
  assign abort_take = abort &&
    (state_q == SETUP || state_q == PULSE || state_q == GAP);
`else
  assign abort_take = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid)
          state_d = (cmd_len != '0) ? SETUP : DONE;
      end
      SETUP: state_d = PULSE;
      PULSE: begin
        if (last)
          state_d = DONE;
        else if (gap_q == '0)
          state_d = PULSE;
        else begin
          state_d  = GAP;
          tmr_load = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero)
          state_d = PULSE;
        else
          tmr_en = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_take) begin
      state_d  = DONE;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  // Timer holds gap-1 so GAP lasts exactly gap cycles.
  counter_drv_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .val_i  (gap_q - 1'b1),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_l_q <= MODE_DOWN;
      len_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_l_q <= cmd_mode;
        len_q    <= cmd_len;
        gap_q    <= cmd_gap;
      end
    end
  end

  // Outputs are decoded from the current state and land one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_DOWN;
      count_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
    end else begin
      count_q <= (state_q == PULSE);
      busy_q  <= (state_q != IDLE);
      done_q  <= (state_q == DONE);
      if (state_q == SETUP)
        mode_q <= mode_l_q;
      if (accept)
        issued_q <= '0;
      else if (state_q == PULSE)
        issued_q <= issued_q + 1'b1;
    end
  end

`ifdef COUNTER_DRV_ABORT_EN
  logic abt_q;
  logic aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abt_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (accept) begin
        abt_q     <= 1'b0;
        aborted_q <= 1'b0;
      end else begin
        if (abort_take)
          abt_q <= 1'b1;
        if (state_q == DONE && abt_q)
          aborted_q <= 1'b1;
      end
    end
  end

  assign aborted = aborted_q;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign mode      = mode_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign issued    = issued_q;

endmodule

// File: tb/tb_counter_stim_driver.sv
// Randomized bench for counter_stim_driver against a per-cycle burst model.
// Define COUNTER_DRV_ABORT_EN to also exercise the abort path.
module tb_counter_stim_driver;

  localparam int CW = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_mode = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic [GW-1:0] cmd_gap = '0;
  logic          mode;
  logic          count;
  logic          busy;
  logic          done;
  logic [CW-1:0] issued;
`ifdef COUNTER_DRV_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  counter_stim_driver #(
    .CNT_W (CW),
    .GAP_W (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_len   (cmd_len),
    .cmd_gap   (cmd_gap),
`ifdef COUNTER_DRV_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .mode      (mode),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .issued    (issued)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   bn = 0;
  logic exp_mode = 1'b0;
  int   exp_iss = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs();
    return 32'({cmd_ready, busy, done, count, mode, issued});
  endfunction

  function automatic logic [31:0] expv(input bit r, input bit b,
                                       input bit d, input bit c,
                                       input bit m, input int i);
    logic [CW-1:0] iv;
    iv = CW'(i);
    return 32'({r, b, d, c, m, iv});
  endfunction

  // Model: pulse n (0-based) lands at cycle 2+n*(g+1); done one cycle
  // after the final pulse, or at cycle 1 for an empty burst.
  task automatic run_burst(input bit m, input int L, input int g,
                           input bit hold, input bit hm,
                           input int hL, input int hg, input bit imm);
    int waits;
    int dk;
    int p;
    int iss;
    bit c;
    waits = 0;
    bn++;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = CW'(L);
    cmd_gap   = GW'(g);
    while (!cmd_ready && waits < 2000) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!cmd_ready) begin
      chk($sformatf("b%0d_accept_timeout", bn), 32'(waits), 32'd0);
      cmd_valid = 1'b0;
      return;
    end
    if (imm)
      chk($sformatf("b%0d_queued_wait", bn), 32'(waits), 32'd0);
    @(posedge clk); #1;
    if (hold) begin
      cmd_mode = hm;
      cmd_len  = CW'(hL);
      cmd_gap  = GW'(hg);
    end else begin
      cmd_valid = 1'b0;
    end
    p  = g + 1;
    dk = (L == 0) ? 1 : 2 + L + (L - 1) * g;
    for (int k = 0; k <= dk; k++) begin
      if (k >= 1 && L > 0)
        exp_mode = m;
      c = (k >= 2) && ((k - 2) % p == 0) && ((k - 2) / p < L);
      iss = (k >= 2) ? ((k - 2) / p + 1) : 0;
      if (iss > L)
        iss = L;
      chk($sformatf("b%0d_k%0d", bn, k), obs(),
          expv(k == dk, k >= 1, k == dk, c, exp_mode, iss));
      if (k < dk) begin
        @(posedge clk); #1;
      end
    end
    exp_iss = L;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_b%0d_%0d", bn, i), obs(),
          expv(1, 0, 0, 0, exp_mode, exp_iss));
    end
  endtask

  task automatic reset_mid_burst();
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_mode  = 1'b1;
    cmd_len   = CW'(5);
    cmd_gap   = GW'(1);
    while (!cmd_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w = 0;
    while (!count && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst_reach_pulse", 32'(count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({count, mode, busy, done, cmd_ready}),
        32'b00001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_mode = 1'b0;
    exp_iss  = 0;
    @(posedge clk); #1;
    chk("rst_release", obs(), expv(1, 0, 0, 0, 0, 0));
  endtask

`ifdef COUNTER_DRV_ABORT_EN
  task automatic abort_burst();
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_mode  = 1'b1;
    cmd_len   = CW'(4);
    cmd_gap   = GW'(3);
    while (!cmd_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abt_k2", obs(), expv(0, 1, 0, 1, 1, 1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abt_k3", obs(), expv(0, 1, 0, 0, 1, 1));
    @(posedge clk); #1;
    chk("abt_k4", obs(), expv(1, 1, 1, 0, 1, 1));
    chk("abt_flag", 32'(aborted), 32'd1);
    @(posedge clk); #1;
    chk("abt_k5", obs(), expv(1, 0, 0, 0, 1, 1));
    exp_mode = 1'b1;
    exp_iss  = 1;
  endtask
`endif

  initial begin
    bit m, nm, h, imm;
    int L, nL, g, ng;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), expv(1, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    idle(1);

    run_burst(1, 3, 0, 0, 0, 0, 0, 0);
    idle(1);
    run_burst(0, 2, 2, 0, 0, 0, 0, 0);
    idle(2);
    run_burst(1, 0, 5, 0, 0, 0, 0, 0);
    idle(1);
    run_burst(1, 4, 1, 1, 0, 3, 2, 0);
    run_burst(0, 3, 2, 0, 0, 0, 0, 1);
    idle(1);
    run_burst(0, 255, 0, 0, 0, 0, 0, 0);
    idle(1);
    run_burst(1, 3, 15, 0, 0, 0, 0, 0);

    m   = 1'($urandom_range(0, 1));
    L   = $urandom_range(0, 12);
    g   = $urandom_range(0, 5);
    imm = 1'b0;
    for (int i = 0; i < 30; i++) begin
      h  = (i == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      nm = 1'($urandom_range(0, 1));
      nL = $urandom_range(0, 12);
      ng = $urandom_range(0, 5);
      run_burst(m, L, g, h, nm, nL, ng, imm);
      if (!h)
        idle($urandom_range(0, 3));
      m   = nm;
      L   = nL;
      g   = ng;
      imm = h;
    end

    reset_mid_burst();
`ifdef COUNTER_DRV_ABORT_EN
    abort_burst();
    idle(1);
`endif
    run_burst(1, 2, 0, 0, 0, 0, 0, 0);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
